// File: rtl/gcd_pkg.sv
// Shared types and helpers for the round-robin GCD request arbiter.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } gcd_arb_state_e;

  // Index width that stays at least one bit wide even for a single requester.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: first valid requester after the pointer, with wrap.
module gcd_rr_pick import gcd_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_j;
  logic            w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    // Search offsets 1..NUM_REQ so the pointer's own slot is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_valid[w_j]) begin
        w_found       = 1'b1;
        o_grant[w_j]  = 1'b1;
        o_idx         = w_j;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Round-robin front end that shares one subtractive GCD engine between NUM_REQ clients.
module gcd_req_arbiter import gcd_pkg::*; #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 0,
  localparam int unsigned ID_W       = clog2_min1(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_b,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic [ID_W-1:0]            o_resp_id,
  output logic [DATA_W-1:0]          o_resp_result,
  output logic                       o_resp_err,
  output logic                       o_eng_start,
  output logic [DATA_W-1:0]          o_eng_a,
  output logic [DATA_W-1:0]          o_eng_b,
  input  logic                       i_eng_done,
  input  logic [DATA_W-1:0]          i_eng_result
);

  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  gcd_arb_state_e       r_state;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [DATA_W-1:0]    r_eng_a;
  logic [DATA_W-1:0]    r_eng_b;
  logic                 r_eng_start;
  logic [DATA_W-1:0]    r_result;
  logic                 r_err;
  logic                 r_resp_valid;
  logic [31:0]          r_cnt;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_idx;
  logic                 w_any;
  logic [DATA_W-1:0]    w_sel_a;
  logic [DATA_W-1:0]    w_sel_b;
  logic                 w_accept;

  gcd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = i_req_a[i*DATA_W +: DATA_W];
        w_sel_b = i_req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Grant is Mealy so the winning client sees ready in the same cycle it is picked.
  assign w_accept    = (r_state == IDLE) && w_any;
  assign o_req_ready = w_accept ? w_grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_eng_a      <= '0;
      r_eng_b      <= '0;
      r_eng_start  <= 1'b0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_eng_a <= w_sel_a;
            r_eng_b <= w_sel_b;
            r_id    <= w_idx;
            r_ptr   <= w_idx;
            // The engine never terminates on a zero operand, so answer locally.
            if ((w_sel_a == '0) || (w_sel_b == '0)) begin
              r_result     <= w_sel_a | w_sel_b;
              r_err        <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_eng_start <= 1'b1;
              r_state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_eng_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= BUSY;
        end
        BUSY: begin
          if (i_eng_done) begin
            r_result     <= i_eng_result;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else if (TO_EN && (r_cnt == TO_LAST)) begin
            r_result     <= '0;
            r_err        <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_eng_start  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign o_resp_valid  = r_resp_valid;
  assign o_resp_id     = r_id;
  assign o_resp_result = r_result;
  assign o_resp_err    = r_err;
  assign o_eng_start   = r_eng_start;
  assign o_eng_a       = r_eng_a;
  assign o_eng_b       = r_eng_b;

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter with a behavioural fixed-latency GCD engine.
module tb_gcd_req_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_err;
  logic         eng_start;
  logic [31:0]  eng_a;
  logic [31:0]  eng_b;
  logic         eng_done;
  logic [31:0]  eng_result;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_req_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_resp_valid  (resp_valid),
    .i_resp_ready  (resp_ready),
    .o_resp_id     (resp_id),
    .o_resp_result (resp_result),
    .o_resp_err    (resp_err),
    .o_eng_start   (eng_start),
    .o_eng_a       (eng_a),
    .o_eng_b       (eng_b),
    .i_eng_done    (eng_done),
    .i_eng_result  (eng_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: result appears a few cycles after start unless muted.
  logic        m_mute;
  logic        m_done;
  logic        m_run;
  logic        inj_done;
  logic [31:0] m_a, m_b;
  int          m_cnt;

  function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run      <= 1'b0;
      m_done     <= 1'b0;
      m_cnt      <= 0;
      m_a        <= '0;
      m_b        <= '0;
      eng_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (eng_start) begin
        m_a   <= eng_a;
        m_b   <= eng_b;
        m_cnt <= 3;
        m_run <= 1'b1;
      end else if (m_run) begin
        if (m_cnt == 0) begin
          m_run      <= 1'b0;
          m_done     <= !m_mute;
          eng_result <= gcd_f(m_a, m_b);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign eng_done = m_done | inj_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(resp_valid), 64'd1);
  endtask

  task automatic set_ops(input int unsigned r, input logic [31:0] a, input logic [31:0] b);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
  endtask

  task automatic do_op(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit byp);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    set_ops(r, a, b);
    #1;
    chk("grant", 64'(req_ready), 64'(4'b0001 << r));
    tick();
    req_valid = '0;
    if (byp) begin
      chk("bypass_valid", 64'(resp_valid), 64'd1);
      chk("bypass_no_start", 64'(eng_start), 64'd0);
    end else begin
      chk("eng_start", 64'(eng_start), 64'd1);
      chk("eng_a", 64'(eng_a), 64'(a));
      chk("eng_b", 64'(eng_b), 64'(b));
      tick();
      chk("start_one_cycle", 64'(eng_start), 64'd0);
      wait_resp("resp_timeout");
    end
    chk("resp_id", 64'(resp_id), 64'(r));
    chk("resp_result", 64'(resp_result), 64'(exp));
    chk("resp_err", 64'(resp_err), 64'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  typedef struct {
    int unsigned req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          byp;
  } vec_t;

  vec_t vecs[6];
  logic [3:0]  exp_g[5];
  logic [31:0] exp_r[5];

  initial begin
    vecs[0] = '{req: 0, a: 32'd48,  b: 32'd18, exp: 32'd6,  byp: 1'b0};
    vecs[1] = '{req: 1, a: 32'd0,   b: 32'd9,  exp: 32'd9,  byp: 1'b1};
    vecs[2] = '{req: 3, a: 32'd0,   b: 32'd0,  exp: 32'd0,  byp: 1'b1};
    vecs[3] = '{req: 2, a: 32'd35,  b: 32'd21, exp: 32'd7,  byp: 1'b0};
    vecs[4] = '{req: 1, a: 32'd17,  b: 32'd5,  exp: 32'd1,  byp: 1'b0};
    vecs[5] = '{req: 3, a: 32'd81,  b: 32'd0,  exp: 32'd81, byp: 1'b1};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    m_mute     = 1'b0;
    inj_done   = 1'b0;
    #12;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_a", 64'(eng_a), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single ops and zero bypass.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].byp);
    end

    // All requesters valid continuously; pointer is at 3 after the table.
    set_ops(0, 32'd48,  32'd18);
    set_ops(1, 32'd12,  32'd8);
    set_ops(2, 32'd35,  32'd21);
    set_ops(3, 32'd100, 32'd75);
    exp_g[0] = 4'b0001; exp_r[0] = 32'd6;
    exp_g[1] = 4'b0010; exp_r[1] = 32'd4;
    exp_g[2] = 4'b0100; exp_r[2] = 32'd7;
    exp_g[3] = 4'b1000; exp_r[3] = 32'd25;
    exp_g[4] = 4'b0001; exp_r[4] = 32'd6;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 64'(req_ready), 64'(exp_g[i]));
      tick();
      chk("rr_start", 64'(eng_start), 64'd1);
      chk("rr_no_grant_launch", 64'(req_ready), 64'd0);
      wait_resp("rr_timeout");
      chk("rr_id", 64'(resp_id), 64'(i % 4));
      chk("rr_result", 64'(resp_result), 64'(exp_r[i]));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end

    // Backpressure: pointer at 0, so requester 1 wins (12,8 -> 4).
    chk("bp_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    wait_resp("bp_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_id", 64'(resp_id), 64'd1);
      chk("bp_result", 64'(resp_result), 64'd4);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_no_start", 64'(eng_start), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req_valid  = '0;

    // Watchdog: engine never answers.
    m_mute = 1'b1;
    req_valid = 4'b0100;
    set_ops(2, 32'd9, 32'd6);
    #1;
    chk("wd_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    chk("wd_start", 64'(eng_start), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("wd_not_early", 64'(resp_valid), 64'd0);
    end
    tick();
    chk("wd_valid", 64'(resp_valid), 64'd1);
    chk("wd_err", 64'(resp_err), 64'd1);
    chk("wd_result", 64'(resp_result), 64'd0);
    chk("wd_id", 64'(resp_id), 64'd2);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    inj_done   = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("late_done_ignored", 64'(resp_valid), 64'd0);
    tick();
    chk("late_done_idle", 64'(resp_valid), 64'd0);

    // Reset while BUSY; requester 1 wins first so the pointer is not already at 3.
    req_valid = 4'b0010;
    set_ops(1, 32'd48, 32'd18);
    tick();
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("rb_resp_valid", 64'(resp_valid), 64'd0);
    chk("rb_eng_start", 64'(eng_start), 64'd0);
    chk("rb_eng_a", 64'(eng_a), 64'd0);
    chk("rb_eng_b", 64'(eng_b), 64'd0);
    chk("rb_resp_id", 64'(resp_id), 64'd0);
    chk("rb_resp_err", 64'(resp_err), 64'd0);
    tick();
    reset_n = 1'b1;
    m_mute  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb_no_resp", 64'(resp_valid), 64'd0);
    end
    req_valid = 4'b1111;
    #1;
    chk("rb_first_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    wait_resp("rb_timeout");
    chk("rb_id", 64'(resp_id), 64'd0);
    chk("rb_result", 64'(resp_result), 64'd6);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
